// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_defs: shared CP0 exception-control constants, encodings and FSM state type
package cp0_defs;
   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_RI = 5'd10;
   localparam logic [4:0] EXC_OV = 5'd12;
   localparam logic [4:0] REG_STA = 5'd12;
   localparam logic [4:0] REG_CAU = 5'd13;
   localparam logic [4:0] REG_EPC = 5'd14;
   localparam logic [1:0] SEL_NPC = 2'd0;
   localparam logic [1:0] SEL_EPC = 2'd1;
   localparam logic [1:0] SEL_HND = 2'd2;
   localparam logic [1:0] MF_ALU = 2'd0;
   localparam logic [1:0] MF_STA = 2'd1;
   localparam logic [1:0] MF_CAU = 2'd2;
   localparam logic [1:0] MF_EPC = 2'd3;
   localparam logic [31:0] HANDLER_ADDR = 32'h0000_0004;
   typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} exc_state_e;
   function automatic logic [31:0] cause_word(input logic [4:0] code);
      return {25'b0, code, 2'b0};
   endfunction
endpackage

// File: rtl/cp0_exc_ctrl_sync_bit.sv
// sync_bit: multi-flop synchronizer for one asynchronous level
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q;
   // shift the raw level through the synchronizer chain
   always_ff @(posedge clk or negedge rst)
      if (!rst) sync_q <= '0;
      else sync_q <= {sync_q[STAGES-2:0], d};
   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/interrupt arbitration, CP0 write control and interrupt handshake
module cp0_exc_ctrl
   import cp0_defs::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        intr,
   output logic        intr_ack,
   input  logic [31:0] sta,
   input  logic        ex_valid,
   input  logic        stall,
   input  logic        ex_syscall,
   input  logic        ex_unimpl,
   input  logic        ex_eret,
   input  logic        ex_mfc0,
   input  logic        ex_mtc0,
   input  logic        ex_ov,
   input  logic [4:0]  ex_rd,
   output logic        exc,
   output logic        inta,
   output logic        wsta,
   output logic        wcau,
   output logic        wepc,
   output logic        mtc0,
   output logic [1:0]  mfc0,
   output logic [1:0]  selpc,
   output logic [31:0] cause,
   output logic        flush
);
   logic intr_s, commit, ev_ov, ev_ri, ev_sys, ev_int, take, take_int;
   logic [4:0] code;
   exc_state_e state_q, state_d;
   logic unused_sta;
   assign unused_sta = ^{sta[31:4], ex_mfc0};
   sync_bit #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(intr), .q(intr_s));
   assign commit = ex_valid & ~stall;
   assign ev_ov = commit & ex_ov & sta[3];
   assign ev_ri = commit & ex_unimpl & sta[2];
   assign ev_sys = commit & ex_syscall & sta[1];
   assign ev_int = ~stall & intr_s & sta[0] & (state_q == IDLE) & ~ex_eret & ~ex_mtc0;
   assign take = ev_ov | ev_ri | ev_sys | ev_int;
   assign take_int = ev_int & ~(ev_ov | ev_ri | ev_sys);
   assign code = ev_ov ? EXC_OV : ev_ri ? EXC_RI : ev_sys ? EXC_SYS : EXC_INT;
   // handshake state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state_q <= IDLE;
      else state_q <= state_d;
   // handshake: ack a taken interrupt until the synced level falls, then one cooldown cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = take_int ? ACK : IDLE;
         ACK:      state_d = intr_s ? ACK : WAIT_LOW;
         default:  state_d = IDLE;
      endcase
   end
   // acknowledge is held only while in ACK
   always_comb intr_ack = state_q == ACK;
   // CP0 controls: exception beats ERET beats MTC0; reset forces everything low
   always_comb begin
      exc = 1'b0;
      inta = 1'b0;
      wsta = 1'b0;
      wcau = 1'b0;
      wepc = 1'b0;
      mtc0 = 1'b0;
      selpc = SEL_NPC;
      cause = '0;
      flush = 1'b0;
      mfc0 = !rst ? MF_ALU : ex_rd == REG_STA ? MF_STA : ex_rd == REG_CAU ? MF_CAU :
             ex_rd == REG_EPC ? MF_EPC : MF_ALU;
      if (!rst) begin
      end else if (take) begin
         {exc, wsta, wcau, wepc, flush} = '1;
         inta = ~(ev_ov | ev_ri);
         selpc = SEL_HND;
         cause = cause_word(code);
      end else if (commit & ex_eret) begin
         wsta = 1'b1;
         flush = 1'b1;
         selpc = SEL_EPC;
      end else if (commit & ex_mtc0) begin
         mtc0 = 1'b1;
         wsta = ex_rd == REG_STA;
         wcau = ex_rd == REG_CAU;
         wepc = ex_rd == REG_EPC;
      end
   end
endmodule
